// File: rtl/serial_word_adder.sv
// Bit-serial LSB-first adder/subtractor over WORD_LEN-bit words with a parallel word output.
// Optional SERIAL_ADD_SAT_EN: sum_word saturates on carry (all ones) or borrow (all zeros).
module serial_word_adder #(
  parameter int WORD_LEN = 4,
  parameter int CNT_W    = $clog2(WORD_LEN)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                line1,
  input  logic                line2,
  input  logic                in_valid,
  input  logic                sub,
  input  logic                clear,
  output logic                outp,
  output logic                out_valid,
  output logic                overflw,
  output logic                word_done,
  output logic [WORD_LEN-1:0] sum_word
);

  typedef enum logic [1:0] {FIRST, MID, LAST} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic                carry;
  logic                mode;
  logic [WORD_LEN-1:0] shadow;

  logic                accept;
  logic                b_inv;
  logic                b;
  logic                cin;
  logic                sum_bit;
  logic                cout;
  logic                ovf_next;
  logic [WORD_LEN-1:0] word_full;
  logic [WORD_LEN-1:0] word_final;

  // Subtraction is A + ~B + 1; the +1 enters as the carry-in of bit 0.
  always_comb begin
    accept   = in_valid & ~clear;
    b_inv    = (state == FIRST) ? sub : mode;
    b        = line2 ^ b_inv;
    cin      = (state == FIRST) ? sub : carry;
    sum_bit  = line1 ^ b ^ cin;
    cout     = (line1 & b) | (line1 & cin) | (b & cin);
    ovf_next = b_inv ^ cout;
    word_full = shadow;
    word_full[WORD_LEN-1] = sum_bit;
    word_final = word_full;
`ifdef SERIAL_ADD_SAT_EN
    if (ovf_next) word_final = b_inv ? '0 : '1;
`else
`endif
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FIRST;
    end else if (in_valid) begin
      case (state)
        FIRST:   state_next = (WORD_LEN == 2) ? LAST : MID;
        MID:     if (bit_cnt == CNT_W'(WORD_LEN - 2)) state_next = LAST;
        LAST:    state_next = FIRST;
        default: state_next = FIRST;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FIRST;
    else        state <= state_next;
  end

  // Stalls leave every arithmetic register untouched so a word resumes seamlessly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outp      <= 1'b0;
      out_valid <= 1'b0;
      overflw   <= 1'b0;
      word_done <= 1'b0;
      sum_word  <= '0;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      mode      <= 1'b0;
      shadow    <= '0;
    end else begin
      out_valid <= accept;
      word_done <= accept && (state == LAST);
      overflw   <= accept && (state == LAST) && ovf_next;
      if (clear) begin
        bit_cnt <= '0;
        carry   <= 1'b0;
        shadow  <= '0;
      end else if (in_valid) begin
        outp            <= sum_bit;
        shadow[bit_cnt] <= sum_bit;
        if (state == FIRST) mode <= sub;
        if (state == LAST) begin
          bit_cnt  <= '0;
          carry    <= 1'b0;
          sum_word <= word_final;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          carry   <= cout;
        end
      end
    end
  end

endmodule
